// File: rtl/read_rw_if.sv
// read_rw shared types and configuration/status register bus.
// read_rw_pkg carries the task/record types and register map; read_rw_if
// bundles the register write and read channels.
package read_rw_pkg;

   typedef struct packed {
      logic [31:0] locale;
      logic [31:0] ts;
      logic [3:0]  ttype;
   } task_t;

   typedef logic [5:0] cq_slice_slot_t;
   typedef logic [3:0] thread_id_t;

   typedef struct packed {
      task_t          task_desc;
      cq_slice_slot_t cq_slot;
      thread_id_t     thread;
      logic [31:0]    object;
   } rw_write_t;

   localparam logic [7:0] RW_BASE_ADDR          = 8'h00;
   localparam logic [7:0] READ_RW_STATUS        = 8'h04;
   localparam logic [7:0] READ_RW_STAT_ISSUED   = 8'h08;
   localparam logic [7:0] READ_RW_STAT_STALL    = 8'h0C;
   localparam logic [7:0] READ_RW_STAT_OUT_BLOCK = 8'h10;

endpackage

interface read_rw_if;
   logic        wvalid;
   logic [7:0]  waddr;
   logic [31:0] wdata;
   logic        arvalid;
   logic [7:0]  araddr;
   logic        rvalid;
   logic [31:0] rdata;

   modport master (
      output wvalid, waddr, wdata, arvalid, araddr,
      input  rvalid, rdata
   );

   modport slave (
      input  wvalid, waddr, wdata, arvalid, araddr,
      output rvalid, rdata
   );
endinterface

// File: rtl/read_rw.sv
// read_rw: issues a data-array read per task (address = base + locale*4),
// matches in-order responses to a pending FIFO, extracts the selected word
// and queues {desc, slot, thread, object} for the write stage.
// Optional statistics counters: define READ_RW_STATS_EN.
module read_rw
   import read_rw_pkg::*;
#(
   parameter int unsigned LOG_OUTSTANDING = 2
) (
   input  logic           clk,
   input  logic           rstn,
   input  logic           task_in_valid,
   output logic           task_in_ready,
   input  task_t          task_in,
   input  cq_slice_slot_t task_in_cq_slot,
   input  thread_id_t     task_in_thread,
   output logic           arvalid,
   input  logic           arready,
   output logic [31:0]    araddr,
   input  logic           rvalid,
   input  logic [511:0]   rdata,
   output logic           task_out_valid,
   input  logic           task_out_ready,
   output rw_write_t      task_out,
   read_rw_if.slave       reg_bus
);

   localparam int unsigned DEPTH = 1 << LOG_OUTSTANDING;
   localparam logic [LOG_OUTSTANDING-1:0] PTR_ONE    = LOG_OUTSTANDING'(1);
   localparam logic [LOG_OUTSTANDING:0]   CNT_ONE    = (LOG_OUTSTANDING+1)'(1);
   localparam logic [LOG_OUTSTANDING+1:0] CREDIT_MAX = (LOG_OUTSTANDING+2)'(DEPTH);

   typedef struct packed {
      task_t          desc;
      cq_slice_slot_t slot;
      thread_id_t     thread;
      logic [3:0]     sel;
   } pend_t;

   pend_t     pend_mem [DEPTH];
   rw_write_t out_mem  [DEPTH];

   logic [LOG_OUTSTANDING-1:0] pend_wr, pend_rd, out_wr, out_rd;
   logic [LOG_OUTSTANDING:0]   pend_cnt, out_cnt;
   logic [LOG_OUTSTANDING+1:0] credit_used;
   logic                       credit_ok;
   logic                       rd_accept, resp_take, resp_orphan, out_pop;
   pend_t                      pend_head;
   logic [31:0]                resp_object;
   logic [31:0]                base_rw_addr;
   logic                       err_orphan;
   logic [31:0]                reg_rd_data;
   logic                       unused_wdata_hi;

`ifdef READ_RW_STATS_EN
   logic [31:0] reads_issued, stall_cycles, out_block_cycles;
`endif

   // Credit check, handshakes and output FIFO head presentation.
   // Credits cover pending + output occupancy so a response always has a slot.
   always_comb begin
      credit_used    = {1'b0, pend_cnt} + {1'b0, out_cnt};
      credit_ok      = credit_used < CREDIT_MAX;
      arvalid        = task_in_valid & credit_ok;
      task_in_ready  = arvalid & arready;
      rd_accept      = task_in_ready;
      araddr         = base_rw_addr + {task_in.locale[29:0], 2'b00};
      resp_take      = rvalid & (pend_cnt != '0);
      resp_orphan    = rvalid & (pend_cnt == '0);
      task_out_valid = out_cnt != '0;
      task_out       = out_mem[out_rd];
      out_pop        = task_out_valid & task_out_ready;
      pend_head      = pend_mem[pend_rd];
      resp_object    = rdata[{pend_head.sel, 5'd0} +: 32];
      unused_wdata_hi = &{1'b0, reg_bus.wdata[31:30]};
   end

   // FIFO storage: pending entry on read accept, output record on response.
   always_ff @(posedge clk) begin
      if (rd_accept) begin
         pend_mem[pend_wr] <= '{desc: task_in, slot: task_in_cq_slot,
                                thread: task_in_thread, sel: task_in.locale[3:0]};
      end
      if (resp_take) begin
         out_mem[out_wr] <= '{task_desc: pend_head.desc, cq_slot: pend_head.slot,
                              thread: pend_head.thread, object: resp_object};
      end
   end

   // FIFO pointers and occupancies; simultaneous push/pop leaves count unchanged.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         pend_wr  <= '0;
         pend_rd  <= '0;
         out_wr   <= '0;
         out_rd   <= '0;
         pend_cnt <= '0;
         out_cnt  <= '0;
      end else begin
         if (rd_accept) pend_wr <= pend_wr + PTR_ONE;
         if (resp_take) begin
            pend_rd <= pend_rd + PTR_ONE;
            out_wr  <= out_wr + PTR_ONE;
         end
         if (out_pop) out_rd <= out_rd + PTR_ONE;

         case ({rd_accept, resp_take})
            2'b10:   pend_cnt <= pend_cnt + CNT_ONE;
            2'b01:   pend_cnt <= pend_cnt - CNT_ONE;
            default: pend_cnt <= pend_cnt;
         endcase

         case ({resp_take, out_pop})
            2'b10:   out_cnt <= out_cnt + CNT_ONE;
            2'b01:   out_cnt <= out_cnt - CNT_ONE;
            default: out_cnt <= out_cnt;
         endcase
      end
   end

   // Base address register and sticky orphan-response flag.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         base_rw_addr <= '0;
         err_orphan   <= 1'b0;
      end else begin
         if (reg_bus.wvalid && reg_bus.waddr == RW_BASE_ADDR) begin
            base_rw_addr <= {reg_bus.wdata[29:0], 2'b00};
         end
         if (resp_orphan) err_orphan <= 1'b1;
      end
   end

   // Register read mux.
   always_comb begin
      reg_rd_data = '0;
      case (reg_bus.araddr)
         READ_RW_STATUS:         reg_rd_data = {31'b0, err_orphan};
`ifdef READ_RW_STATS_EN
         READ_RW_STAT_ISSUED:    reg_rd_data = reads_issued;
         READ_RW_STAT_STALL:     reg_rd_data = stall_cycles;
         READ_RW_STAT_OUT_BLOCK: reg_rd_data = out_block_cycles;
`endif
         default:                reg_rd_data = '0;
      endcase
   end

   // Register read response, one cycle after the request.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         reg_bus.rvalid <= 1'b0;
         reg_bus.rdata  <= '0;
      end else begin
         reg_bus.rvalid <= reg_bus.arvalid;
         if (reg_bus.arvalid) reg_bus.rdata <= reg_rd_data;
      end
   end

`ifdef READ_RW_STATS_EN
   // Wrapping statistics counters.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         reads_issued     <= '0;
         stall_cycles     <= '0;
         out_block_cycles <= '0;
      end else begin
         if (arvalid & arready)              reads_issued     <= reads_issued + 32'd1;
         if (task_in_valid & ~arvalid)       stall_cycles     <= stall_cycles + 32'd1;
         if (task_out_valid & ~task_out_ready) out_block_cycles <= out_block_cycles + 32'd1;
      end
   end
`endif

endmodule
